// File: rtl/wb_io_mux.sv
// ---------------------------------------------------------------------------
// wb_io_mux
//
// Wishbone-controlled pad multiplexer. Each of NPADS pads is driven either by
// the user core (core_io_out/core_io_oeb) or by a GPIO register pair (OUT/OEB),
// selected per bit by the SEL register. Pad inputs are synchronised, readable
// through the IN register, and fed to a per-bit edge detector whose sticky
// status (IRQ_STAT, write-1-to-clear) is masked by IRQ_EN onto a level irq.
//
// Register map (word index = wbs_adr_i[4:2], bits at or above NPADS read 0):
//   0 SEL       1 = core owns the pad
//   1 OUT       GPIO output value
//   2 OEB       GPIO output-enable-bar
//   3 IN        synchronised pad value (read-only)
//   4 IRQ_EN    interrupt enable mask
//   5 IRQ_STAT  edge status, write-1-to-clear
//   6 EDGE      0 = rising, 1 = falling edge detect
//   7 reserved, reads 0
//
// Ports:
//   wb_clk_i      in   1      sole clock, rising edge
//   wb_rst_ni     in   1      asynchronous active-low reset
//   wbs_cyc_i     in   1      Wishbone cycle
//   wbs_stb_i     in   1      Wishbone strobe
//   wbs_we_i      in   1      Wishbone write enable
//   wbs_sel_i     in   4      byte-lane enables
//   wbs_adr_i     in   32     address
//   wbs_dat_i     in   32     write data
//   wbs_ack_o     out  1      one-cycle acknowledge
//   wbs_dat_o     out  32     read data, valid only while ack is high
//   io_in         in   NPADS  pad inputs
//   io_out        out  NPADS  pad outputs
//   io_oeb        out  NPADS  pad output-enable-bar
//   core_io_in    out  NPADS  raw pad inputs towards the core
//   core_io_out   in   NPADS  core-driven pad outputs
//   core_io_oeb   in   NPADS  core-driven pad oeb
//   irq           out  1      level interrupt
// ---------------------------------------------------------------------------
module wb_io_mux #(
    parameter int          NPADS       = 16,
    parameter logic [31:0] ADR_BASE    = 32'h3000_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic [NPADS-1:0]  io_in,
    output logic [NPADS-1:0]  io_out,
    output logic [NPADS-1:0]  io_oeb,
    output logic [NPADS-1:0]  core_io_in,
    input  logic [NPADS-1:0]  core_io_out,
    input  logic [NPADS-1:0]  core_io_oeb,
    output logic              irq
);

    localparam logic [2:0] IDX_SEL  = 3'd0;
    localparam logic [2:0] IDX_OUT  = 3'd1;
    localparam logic [2:0] IDX_OEB  = 3'd2;
    localparam logic [2:0] IDX_IN   = 3'd3;
    localparam logic [2:0] IDX_EN   = 3'd4;
    localparam logic [2:0] IDX_STAT = 3'd5;
    localparam logic [2:0] IDX_EDGE = 3'd6;

    // Register state
    logic [NPADS-1:0] sel_q;
    logic [NPADS-1:0] out_q;
    logic [NPADS-1:0] oeb_q;
    logic [NPADS-1:0] en_q;
    logic [NPADS-1:0] stat_q;
    logic [NPADS-1:0] edge_q;

    logic [NPADS-1:0] sel_d;
    logic [NPADS-1:0] out_d;
    logic [NPADS-1:0] oeb_d;
    logic [NPADS-1:0] en_d;
    logic [NPADS-1:0] stat_d;
    logic [NPADS-1:0] edge_d;

    // Synchroniser: index 0 samples the pad, the top index is the stable value
    logic [SYNC_STAGES-1:0][NPADS-1:0] sync_q;
    logic [NPADS-1:0]                  prev_q;
    logic [NPADS-1:0]                  sync_last;
    logic [NPADS-1:0]                  edge_hit;

    // Bus decode
    logic        hit;
    logic        acc_go;
    logic        wr_go;
    logic        rd_go;
    logic [2:0]  reg_idx;
    logic [31:0] lane_mask;
    logic [NPADS-1:0] wr_mask;
    logic [NPADS-1:0] wr_data;
    logic [NPADS-1:0] w1c_bits;
    logic [31:0] rd_word;

    // Address bits [1:0] and lane bits above NPADS have no function here
    logic unused_ok;
    assign unused_ok = ^{wbs_adr_i[1:0], wbs_dat_i, lane_mask};

    assign hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:5] == ADR_BASE[31:5]);
    assign reg_idx = wbs_adr_i[4:2];

    // An access is accepted only while ack is low, which forces the idle
    // cycle between consecutive acknowledges.
    assign acc_go  = hit & ~wbs_ack_o;
    assign wr_go   = acc_go & wbs_we_i;
    assign rd_go   = acc_go & ~wbs_we_i;

    assign lane_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                        {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign wr_mask   = lane_mask[NPADS-1:0];
    assign wr_data   = wbs_dat_i[NPADS-1:0];
    assign w1c_bits  = wr_mask & wr_data;

    assign sync_last = sync_q[SYNC_STAGES-1];

    // Direction of interest is chosen per bit by EDGE; a change of EDGE alone
    // cannot fire because only a real prev/current difference is considered.
    assign edge_hit = (sync_last & ~prev_q & ~edge_q) |
                      (~sync_last & prev_q & edge_q);

    // Next-state for the writable registers. The hardware set of IRQ_STAT is
    // OR-ed in after the write-1-to-clear so a coincident event is not lost.
    always_comb begin
        sel_d  = sel_q;
        out_d  = out_q;
        oeb_d  = oeb_q;
        en_d   = en_q;
        edge_d = edge_q;
        stat_d = stat_q;
        if (wr_go) begin
            case (reg_idx)
                IDX_SEL:  sel_d  = (sel_q  & ~wr_mask) | (wr_data & wr_mask);
                IDX_OUT:  out_d  = (out_q  & ~wr_mask) | (wr_data & wr_mask);
                IDX_OEB:  oeb_d  = (oeb_q  & ~wr_mask) | (wr_data & wr_mask);
                IDX_EN:   en_d   = (en_q   & ~wr_mask) | (wr_data & wr_mask);
                IDX_EDGE: edge_d = (edge_q & ~wr_mask) | (wr_data & wr_mask);
                IDX_STAT: stat_d = stat_q & ~w1c_bits;
                default:  ;
            endcase
        end
        stat_d = stat_d | edge_hit;
    end

    // Read multiplexer, zero-extended to the bus width
    always_comb begin
        rd_word = '0;
        case (reg_idx)
            IDX_SEL:  rd_word[NPADS-1:0] = sel_q;
            IDX_OUT:  rd_word[NPADS-1:0] = out_q;
            IDX_OEB:  rd_word[NPADS-1:0] = oeb_q;
            IDX_IN:   rd_word[NPADS-1:0] = sync_last;
            IDX_EN:   rd_word[NPADS-1:0] = en_q;
            IDX_STAT: rd_word[NPADS-1:0] = stat_q;
            IDX_EDGE: rd_word[NPADS-1:0] = edge_q;
            default:  rd_word = '0;
        endcase
    end

    // Register file
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sel_q  <= '0;
            out_q  <= '0;
            oeb_q  <= '1;
            en_q   <= '0;
            stat_q <= '0;
            edge_q <= '0;
        end else begin
            sel_q  <= sel_d;
            out_q  <= out_d;
            oeb_q  <= oeb_d;
            en_q   <= en_d;
            stat_q <= stat_d;
            edge_q <= edge_d;
        end
    end

    // Input synchroniser and history flop
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], io_in};
            prev_q <= sync_last;
        end
    end

    // Bus response: read data is only non-zero during the ack cycle
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= acc_go;
            wbs_dat_o <= rd_go ? rd_word : 32'd0;
        end
    end

    assign io_out     = (sel_q & core_io_out) | (~sel_q & out_q);
    assign io_oeb     = (sel_q & core_io_oeb) | (~sel_q & oeb_q);
    assign core_io_in = io_in;
    assign irq        = |(stat_q & en_q);

endmodule

// File: tb/tb_wb_io_mux.sv
// ---------------------------------------------------------------------------
// tb_wb_io_mux
//
// Directed self-checking bench for wb_io_mux (NPADS = 16, SYNC_STAGES = 2).
// Expected read data is queued when a read is issued and popped when the
// acknowledge arrives.
// ---------------------------------------------------------------------------
module tb_wb_io_mux;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk;
    logic        rst_n;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic        ack;
    logic [31:0] dat_r;
    logic [15:0] io_in;
    logic [15:0] io_out;
    logic [15:0] io_oeb;
    logic [15:0] core_in;
    logic [15:0] core_out;
    logic [15:0] core_oeb;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] expQ[$];

    wb_io_mux #(
        .NPADS(16),
        .ADR_BASE(32'h3000_0000),
        .SYNC_STAGES(2)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_ni(rst_n),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_we_i(we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(dat_w),
        .wbs_ack_o(ack),
        .wbs_dat_o(dat_r),
        .io_in(io_in),
        .io_out(io_out),
        .io_oeb(io_oeb),
        .core_io_in(core_in),
        .core_io_out(core_out),
        .core_io_oeb(core_oeb),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout, expected sequence end");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic cs, input logic w, input logic [31:0] a,
                                 input logic [31:0] d, input logic [3:0] s);
        cyc   = cs;
        stb   = cs;
        we    = w;
        adr   = a;
        dat_w = d;
        sel   = s;
    endtask

    // One Wishbone access starting at the next falling edge. Optionally checks
    // irq at the sample point right after the acknowledge edge.
    task automatic busCycle(input string tag, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s,
                            input bit expectAck, input bit chkIrq, input logic expIrq);
        int n;
        logic [31:0] e;
        @(negedge clk);
        applyStimulus(1'b1, w, a, d, s);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 4);
        if (expectAck) begin
            checkOutput({tag, "/ackLatency"}, 32'(n), 32'd1);
            if (chkIrq) checkOutput({tag, "/irqAtCommit"}, 32'(irq), 32'(expIrq));
            if (!w) begin
                checks++;
                assert (expQ.size() != 0)
                else begin
                    errors++;
                    $error("[TB] FAIL %s/scoreboard: observed empty queue, expected entry", tag);
                end
                if (expQ.size() != 0) begin
                    e = expQ.pop_front();
                    checkOutput({tag, "/rdata"}, dat_r, e);
                end
            end
        end else begin
            checkOutput({tag, "/noAck"}, 32'(ack), 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        checkOutput({tag, "/ackLow"}, 32'(ack), 32'd0);
        checkOutput({tag, "/datIdle"}, dat_r, 32'd0);
    endtask

    task automatic busWrite(input string tag, input int idx, input logic [31:0] d,
                            input logic [3:0] s);
        busCycle(tag, 1'b1, BASE + 32'(idx * 4), d, s, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic busRead(input string tag, input int idx, input logic [31:0] exp);
        expQ.push_back(exp);
        busCycle(tag, 1'b0, BASE + 32'(idx * 4), 32'd0, 4'hF, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n    = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        io_in    = 16'h0000;
        core_out = 16'hFFFF;
        core_oeb = 16'h0000;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst/ack", 32'(ack), 32'd0);
        checkOutput("rst/dat", dat_r, 32'd0);
        checkOutput("rst/irq", 32'(irq), 32'd0);
        checkOutput("rst/io_oeb", 32'(io_oeb), 32'h0000_FFFF);
        checkOutput("rst/io_out", 32'(io_out), 32'd0);
        rst_n = 1'b1;

        // Register map after reset
        busRead("rd/SEL", 0, 32'h0);
        busRead("rd/OUT", 1, 32'h0);
        busRead("rd/OEB", 2, 32'h0000_FFFF);
        busRead("rd/IN", 3, 32'h0);
        busRead("rd/IRQ_EN", 4, 32'h0);
        busRead("rd/IRQ_STAT", 5, 32'h0);
        busRead("rd/EDGE", 6, 32'h0);
        busRead("rd/RSVD", 7, 32'h0);

        // Pad mux
        busWrite("wr/OUT", 1, 32'h0000_A5A5, 4'hF);
        busWrite("wr/OEB", 2, 32'h0000_0000, 4'hF);
        core_out = 16'hFFFF;
        core_oeb = 16'h0000;
        busWrite("wr/SEL", 0, 32'h0000_00FF, 4'hF);
        checkOutput("mux1/io_out", 32'(io_out), 32'h0000_A5FF);
        checkOutput("mux1/io_oeb", 32'(io_oeb), 32'h0000_0000);
        core_out = 16'h0000;
        core_oeb = 16'hFFFF;
        #1;
        checkOutput("mux2/io_out", 32'(io_out), 32'h0000_A500);
        checkOutput("mux2/io_oeb", 32'(io_oeb), 32'h0000_00FF);
        busRead("rd/SEL2", 0, 32'h0000_00FF);
        busWrite("wr/SEL0", 0, 32'h0, 4'hF);

        // Byte lanes
        busWrite("wr/OUTclr", 1, 32'h0, 4'hF);
        busWrite("wr/OUTlane1", 1, 32'h1234_5678, 4'b0010);
        busRead("rd/OUTlane1", 1, 32'h0000_5600);
        busWrite("wr/OUTsel0", 1, 32'hFFFF_FFFF, 4'b0000);
        busRead("rd/OUTsel0", 1, 32'h0000_5600);
        checkOutput("gpio/io_out", 32'(io_out), 32'h0000_5600);
        busWrite("wr/ENall", 4, 32'hFFFF_FFFF, 4'hF);
        busRead("rd/ENall", 4, 32'h0000_FFFF);
        busWrite("wr/ENoff", 4, 32'h0, 4'hF);
        busWrite("wr/IN", 3, 32'h0000_FFFF, 4'hF);
        busRead("rd/INro", 3, 32'h0);
        busWrite("wr/RSVD", 7, 32'hFFFF_FFFF, 4'hF);
        busRead("rd/RSVD2", 7, 32'h0);

        // Rising edge on pad 0: status two edges after the sampling edge
        busWrite("wr/EN1", 4, 32'h1, 4'hF);
        busWrite("wr/EDGE0", 6, 32'h0, 4'hF);
        io_in[0] = 1'b1;
        @(negedge clk);
        checkOutput("edge0/irqK", 32'(irq), 32'd0);
        @(negedge clk);
        checkOutput("edge0/irqK1", 32'(irq), 32'd0);
        @(negedge clk);
        checkOutput("edge0/irqK2", 32'(irq), 32'd1);
        checkOutput("core_io_in", 32'(core_in), 32'h0000_0001);
        busRead("rd/IN1", 3, 32'h1);
        busRead("rd/STAT1", 5, 32'h1);
        busCycle("w1c/STAT1", 1'b1, BASE + 32'd20, 32'h1, 4'hF, 1'b1, 1'b1, 1'b0);
        busRead("rd/STAT1clr", 5, 32'h0);

        // Falling edge on pad 1 colliding with a W1C of the same bit
        busWrite("wr/EN2", 4, 32'h2, 4'hF);
        busWrite("wr/EDGE2", 6, 32'h2, 4'hF);
        io_in[1] = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("edge1/riseIgnored", 32'(irq), 32'd0);
        busRead("rd/STATnoRise", 5, 32'h0);
        io_in[1] = 1'b0;
        @(negedge clk);
        busCycle("w1c/collide", 1'b1, BASE + 32'd20, 32'h2, 4'hF, 1'b1, 1'b1, 1'b1);
        busRead("rd/STATkept", 5, 32'h2);
        busCycle("w1c/STAT2", 1'b1, BASE + 32'd20, 32'h2, 4'hF, 1'b1, 1'b1, 1'b0);
        busWrite("wr/EDGEback", 6, 32'h0, 4'hF);
        busRead("rd/STATedgeChg", 5, 32'h0);

        // Non-hit address and abandoned access
        busCycle("miss/adr20", 1'b1, 32'h3000_0020, 32'hFFFF, 4'hF, 1'b0, 1'b0, 1'b0);
        busRead("rd/SELmiss", 0, 32'h0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, BASE + 32'd4, 32'h0000_BEEF, 4'hF);
        #2;
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        checkOutput("drop/ack", 32'(ack), 32'd0);
        busRead("rd/OUTdrop", 1, 32'h0000_5600);

        // Reset in the middle of an access, pads held high through reset
        io_in = 16'h8001;
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, BASE + 32'd4, 32'h0000_1111, 4'hF);
        @(posedge clk);
        #1;
        checkOutput("midrst/ackBefore", 32'(ack), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst/ackDrop", 32'(ack), 32'd0);
        checkOutput("midrst/dat", dat_r, 32'd0);
        checkOutput("midrst/io_oeb", 32'(io_oeb), 32'h0000_FFFF);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        busRead("rd/OUTrst", 1, 32'h0);
        busRead("rd/STATrelease", 5, 32'h0000_8001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
